// File: rtl/mem_bus_arbiter_rr_if.sv
// Agent/bus bundle for mem_bus_arbiter_rr: requester side, response side and memory bus side.
// Carries timeout_err only when ARB_TIMEOUT_EN is defined.
interface mem_bus_arbiter_rr_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                           system_flush;
   logic                           system_stall;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
   logic [NUM_REQ-1:0]             grant;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [DATA_WIDTH-1:0]          rsp_data;
   logic                           busy;
   logic                           mem_req_valid;
   logic [ADDR_WIDTH-1:0]          mem_addr;
   logic                           mem_we;
   logic [DATA_WIDTH-1:0]          mem_wdata;
   logic [DATA_WIDTH-1:0]          mem_rd_data;
   logic                           mem_data_valid;
`ifdef ARB_TIMEOUT_EN
   logic                           timeout_err;
`endif

   // Agents and the memory bus drive the arbiter through this view.
   modport master (
      output system_flush, system_stall, req_valid, req_addr, req_we, req_wdata,
             mem_rd_data, mem_data_valid,
      input  grant, rsp_valid, rsp_data, busy, mem_req_valid, mem_addr, mem_we, mem_wdata
`ifdef ARB_TIMEOUT_EN
      , input timeout_err
`endif
   );

   modport slave (
      input  system_flush, system_stall, req_valid, req_addr, req_we, req_wdata,
             mem_rd_data, mem_data_valid,
      output grant, rsp_valid, rsp_data, busy, mem_req_valid, mem_addr, mem_we, mem_wdata
`ifdef ARB_TIMEOUT_EN
      , output timeout_err
`endif
   );
endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// N-requester arbiter onto the single main-memory bus, one outstanding transaction at a time.
// Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter_rr #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int ARB_MODE       = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                clk,
   input logic                reset,
   mem_bus_arbiter_rr_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_ptr;
   logic [IDX_W-1:0]       r_owner;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic                   r_we;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [DATA_WIDTH-1:0]  r_rsp_data;
   logic [NUM_REQ-1:0]     r_grant;
   logic [NUM_REQ-1:0]     r_rsp_valid;
   logic                   r_mem_req_valid;
   logic                   r_busy;

   state_t                 w_state_nxt;
   logic [IDX_W-1:0]       w_ptr_nxt;
   logic [IDX_W-1:0]       w_owner_nxt;
   logic [ADDR_WIDTH-1:0]  w_addr_nxt;
   logic                   w_we_nxt;
   logic [DATA_WIDTH-1:0]  w_wdata_nxt;
   logic [DATA_WIDTH-1:0]  w_rsp_data_nxt;
   logic [NUM_REQ-1:0]     w_grant_nxt;
   logic [NUM_REQ-1:0]     w_rsp_valid_nxt;
   logic                   w_mem_req_valid_nxt;
   logic                   w_busy_nxt;
   logic [IDX_W-1:0]       w_winner;
   logic                   w_any_req;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_timeout_err;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_timeout_err_nxt;
`endif

   // Fixed mode: lowest index wins. Round-robin: search starts just after the last owner.
   function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                    input logic [IDX_W-1:0]   last);
      logic [IDX_W-1:0] win;
      logic             found;
      int unsigned      idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ARB_MODE == 0) begin
            idx = unsigned'(k);
         end else begin
            idx = (32'(last) + unsigned'(k) + 32'd1) % unsigned'(NUM_REQ);
         end
         if (!found && req[idx[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = idx[IDX_W-1:0];
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

   assign w_any_req = |bus.req_valid;
   assign w_winner  = pick_winner(bus.req_valid, r_ptr);

   // Next-state and next-output decode; flush beats stall, stall freezes everything.
   always_comb begin
      w_state_nxt         = r_state;
      w_ptr_nxt           = r_ptr;
      w_owner_nxt         = r_owner;
      w_addr_nxt          = r_addr;
      w_we_nxt            = r_we;
      w_wdata_nxt         = r_wdata;
      w_rsp_data_nxt      = r_rsp_data;
      w_grant_nxt         = r_grant;
      w_rsp_valid_nxt     = r_rsp_valid;
      w_mem_req_valid_nxt = r_mem_req_valid;
`ifdef ARB_TIMEOUT_EN
      w_cnt_nxt           = r_cnt;
      w_timeout_err_nxt   = r_timeout_err;
`endif
      if (bus.system_flush) begin
         w_state_nxt         = ST_IDLE;
         w_grant_nxt         = '0;
         w_rsp_valid_nxt     = '0;
         w_mem_req_valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
         w_cnt_nxt           = '0;
         w_timeout_err_nxt   = 1'b0;
`endif
      end else if (!bus.system_stall) begin
         w_grant_nxt         = '0;
         w_rsp_valid_nxt     = '0;
         w_mem_req_valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
         w_timeout_err_nxt   = 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  w_owner_nxt           = w_winner;
                  w_addr_nxt            = bus.req_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                  w_we_nxt              = bus.req_we[w_winner];
                  w_wdata_nxt           = bus.req_wdata[w_winner*DATA_WIDTH +: DATA_WIDTH];
                  w_grant_nxt[w_winner] = 1'b1;
                  w_mem_req_valid_nxt   = 1'b1;
                  w_ptr_nxt             = w_winner;
                  w_state_nxt           = ST_REQ;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_REQ: begin
               w_state_nxt = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
               w_cnt_nxt   = '0;
`endif
            end
            ST_WAIT: begin
               if (bus.mem_data_valid) begin
                  w_rsp_valid_nxt[r_owner] = 1'b1;
                  if (!r_we) begin
                     w_rsp_data_nxt = bus.mem_rd_data;
                  end else begin
                     w_rsp_data_nxt = r_rsp_data;
                  end
                  w_state_nxt = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
               end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Watchdog completes the transaction with zero data.
                  w_rsp_valid_nxt[r_owner] = 1'b1;
                  w_rsp_data_nxt           = '0;
                  w_timeout_err_nxt        = 1'b1;
                  w_state_nxt              = ST_IDLE;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
                  w_state_nxt = ST_WAIT;
               end
`else
               end else begin
                  w_state_nxt = ST_WAIT;
               end
`endif
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // State, pointer, latched request and all outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_ptr           <= IDX_W'(NUM_REQ - 1);
         r_owner         <= '0;
         r_addr          <= '0;
         r_we            <= 1'b0;
         r_wdata         <= '0;
         r_rsp_data      <= '0;
         r_grant         <= '0;
         r_rsp_valid     <= '0;
         r_mem_req_valid <= 1'b0;
         r_busy          <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_cnt           <= '0;
         r_timeout_err   <= 1'b0;
`endif
      end else begin
         r_state         <= w_state_nxt;
         r_ptr           <= w_ptr_nxt;
         r_owner         <= w_owner_nxt;
         r_addr          <= w_addr_nxt;
         r_we            <= w_we_nxt;
         r_wdata         <= w_wdata_nxt;
         r_rsp_data      <= w_rsp_data_nxt;
         r_grant         <= w_grant_nxt;
         r_rsp_valid     <= w_rsp_valid_nxt;
         r_mem_req_valid <= w_mem_req_valid_nxt;
         r_busy          <= w_busy_nxt;
`ifdef ARB_TIMEOUT_EN
         r_cnt           <= w_cnt_nxt;
         r_timeout_err   <= w_timeout_err_nxt;
`endif
      end
   end

   assign bus.grant         = r_grant;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_data      = r_rsp_data;
   assign bus.busy          = r_busy;
   assign bus.mem_req_valid = r_mem_req_valid;
   assign bus.mem_addr      = r_addr;
   assign bus.mem_we        = r_we;
   assign bus.mem_wdata     = r_wdata;
`ifdef ARB_TIMEOUT_EN
   assign bus.timeout_err   = r_timeout_err;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter_rr.sv
// Bench for mem_bus_arbiter_rr: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requesters/bus/stall/flush.
module tb_mem_bus_arbiter_rr;
   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   fp_grants = 0;

   mem_bus_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
   mem_bus_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fp ();

   mem_bus_arbiter_rr #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1),
                        .TIMEOUT_CYCLES(TO))
      u_dut (.clk(clk), .reset(reset), .bus(bus_rr.slave));

   mem_bus_arbiter_rr #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0),
                        .TIMEOUT_CYCLES(TO))
      u_dut_fp (.clk(clk), .reset(reset), .bus(bus_fp.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit          m_active;
   bit          m_granting;
   int          m_owner;
   int          m_last;
   int          m_wait_n;
   logic [3:0]  e_grant, e_rsp_valid;
   logic        e_mreq, e_busy, e_mem_we, e_toerr;
   logic [31:0] e_mem_addr, e_mem_wdata, e_rsp_data;

   function automatic int rr_winner(input logic [3:0] rq, input int last);
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (last + k) % NR;
         if (rq[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_active = 0; m_granting = 0; m_owner = 0; m_last = NR - 1; m_wait_n = 0;
      e_grant = '0; e_rsp_valid = '0; e_mreq = 1'b0; e_busy = 1'b0; e_mem_we = 1'b0;
      e_toerr = 1'b0; e_mem_addr = '0; e_mem_wdata = '0; e_rsp_data = '0;
   endtask

   task automatic model_step();
      int w;
      if (bus_rr.system_flush) begin
         m_active = 0; e_grant = '0; e_rsp_valid = '0; e_mreq = 1'b0; e_busy = 1'b0;
         e_toerr = 1'b0;
      end else if (!bus_rr.system_stall) begin
         e_grant = '0; e_rsp_valid = '0; e_mreq = 1'b0; e_toerr = 1'b0;
         if (!m_active) begin
            if (bus_rr.req_valid != 4'b0000) begin
               w = rr_winner(bus_rr.req_valid, m_last);
               m_last = w; m_owner = w; m_active = 1; m_granting = 1;
               e_grant     = 4'b0001 << w;
               e_mreq      = 1'b1;
               e_mem_addr  = bus_rr.req_addr[w*AW +: AW];
               e_mem_we    = bus_rr.req_we[w];
               e_mem_wdata = bus_rr.req_wdata[w*DW +: DW];
            end
         end else if (m_granting) begin
            m_granting = 0;
            m_wait_n   = 0;
         end else if (bus_rr.mem_data_valid) begin
            e_rsp_valid = 4'b0001 << m_owner;
            if (!e_mem_we) e_rsp_data = bus_rr.mem_rd_data;
            m_active = 0;
         end else begin
            m_wait_n++;
`ifdef ARB_TIMEOUT_EN
            if (m_wait_n == TO) begin
               e_rsp_valid = 4'b0001 << m_owner;
               e_rsp_data  = '0;
               e_toerr     = 1'b1;
               m_active    = 0;
            end
`endif
         end
         e_busy = m_active;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison against the model, plus the fixed-priority instance.
   initial begin
      forever begin
         @(negedge clk);
         chk("grant", bus_rr.grant, e_grant);
         chk("rsp_valid", bus_rr.rsp_valid, e_rsp_valid);
         chk("rsp_data", bus_rr.rsp_data, e_rsp_data);
         chk("busy", bus_rr.busy, e_busy);
         chk("mem_req_valid", bus_rr.mem_req_valid, e_mreq);
         chk("mem_addr", bus_rr.mem_addr, e_mem_addr);
         chk("mem_we", bus_rr.mem_we, e_mem_we);
         chk("mem_wdata", bus_rr.mem_wdata, e_mem_wdata);
`ifdef ARB_TIMEOUT_EN
         chk("timeout_err", bus_rr.timeout_err, e_toerr);
`endif
         if (reset && (bus_fp.grant != 4'b0000)) begin
            chk("fp_grant", bus_fp.grant, 4'b0001);
            fp_grants++;
         end
      end
   end

   // Fixed-priority instance: all requesters held, bus always acknowledging.
   initial begin
      bus_fp.system_flush   = 1'b0;
      bus_fp.system_stall   = 1'b0;
      bus_fp.req_valid      = 4'hF;
      bus_fp.req_addr       = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
      bus_fp.req_we         = 4'h0;
      bus_fp.req_wdata      = '0;
      bus_fp.mem_data_valid = 1'b1;
      bus_fp.mem_rd_data    = 32'h0000_F00D;
   end

   task automatic issue(input int idx, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata);
      bus_rr.req_addr[idx*AW +: AW]  = addr;
      bus_rr.req_we[idx]             = we;
      bus_rr.req_wdata[idx*DW +: DW] = wdata;
      bus_rr.req_valid               = 4'b0001 << idx;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         seq[5];
      int         exp_rr[5];
      int         got;
      logic [3:0] prev_g;
      exp_rr = '{0, 1, 2, 3, 0};
      seq    = '{-1, -1, -1, -1, -1};
      bus_rr.system_flush = 1'b0; bus_rr.system_stall = 1'b0;
      bus_rr.req_valid = '0; bus_rr.req_addr = '0; bus_rr.req_we = '0; bus_rr.req_wdata = '0;
      bus_rr.mem_data_valid = 1'b0; bus_rr.mem_rd_data = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_grant", bus_rr.grant, 4'b0000);
      chk("rst_busy", bus_rr.busy, 1'b0);
      chk("rst_mem_req_valid", bus_rr.mem_req_valid, 1'b0);
      chk("rst_rsp_data", bus_rr.rsp_data, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Round-robin with all four held continuously and an always-ready bus.
      bus_rr.req_addr  = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
      bus_rr.req_valid = 4'hF;
      bus_rr.mem_data_valid = 1'b1;
      bus_rr.mem_rd_data    = 32'hA5A5_0000;
      got = 0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         @(negedge clk);
         if (bus_rr.grant != 4'b0000) begin
            for (int i = 0; i < NR; i++) if (bus_rr.grant[i]) seq[got] = i;
            got++;
            if (got == 5) bus_rr.req_valid = 4'h0;
         end
      end
      chk("rr_grant_count", 64'(got), 64'd5);
      for (int k = 0; k < 5; k++) chk("rr_order", 64'(seq[k]), 64'(exp_rr[k]));
      repeat (3) @(negedge clk);
      bus_rr.mem_data_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Single read from requester 1, ack two cycles after the bus request.
      issue(1, 32'h100, 1'b0, 32'h0);
      @(negedge clk);
      chk("rd_grant", bus_rr.grant, 4'b0010);
      chk("rd_mem_req_valid", bus_rr.mem_req_valid, 1'b1);
      chk("rd_mem_addr", bus_rr.mem_addr, 32'h100);
      chk("rd_mem_we", bus_rr.mem_we, 1'b0);
      bus_rr.req_valid = 4'h0;
      @(negedge clk);
      chk("rd_wait_busy", bus_rr.busy, 1'b1);
      chk("rd_wait_mreq", bus_rr.mem_req_valid, 1'b0);
      @(negedge clk);
      bus_rr.mem_data_valid = 1'b1; bus_rr.mem_rd_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rd_rsp_valid", bus_rr.rsp_valid, 4'b0010);
      chk("rd_rsp_data", bus_rr.rsp_data, 32'hDEAD_BEEF);
      bus_rr.mem_data_valid = 1'b0;
      @(negedge clk);
      chk("rd_rsp_pulse_end", bus_rr.rsp_valid, 4'b0000);
      chk("rd_idle", bus_rr.busy, 1'b0);

      // Write from requester 2; an ack raised during REQ is ignored, the WAIT one completes.
      issue(2, 32'h20, 1'b1, 32'h55AA);
      @(negedge clk);
      chk("wr_grant", bus_rr.grant, 4'b0100);
      chk("wr_mem_we", bus_rr.mem_we, 1'b1);
      chk("wr_mem_wdata", bus_rr.mem_wdata, 32'h55AA);
      chk("wr_mem_addr", bus_rr.mem_addr, 32'h20);
      bus_rr.req_valid = 4'h0;
      bus_rr.mem_data_valid = 1'b1; bus_rr.mem_rd_data = 32'h1234_5678;
      @(negedge clk);
      chk("wr_req_ack_ignored", bus_rr.rsp_valid, 4'b0000);
      @(negedge clk);
      chk("wr_rsp_valid", bus_rr.rsp_valid, 4'b0100);
      chk("wr_rsp_data_kept", bus_rr.rsp_data, 32'hDEAD_BEEF);
      bus_rr.mem_data_valid = 1'b0;
      @(negedge clk);

      // Flush in WAIT, late ack must not produce a response.
      issue(0, 32'h40, 1'b0, 32'h0);
      @(negedge clk);
      chk("fl_grant", bus_rr.grant, 4'b0001);
      bus_rr.req_valid = 4'h0;
      @(negedge clk);
      bus_rr.system_flush = 1'b1;
      @(negedge clk);
      chk("fl_busy", bus_rr.busy, 1'b0);
      chk("fl_rsp_valid", bus_rr.rsp_valid, 4'b0000);
      bus_rr.system_flush = 1'b0;
      bus_rr.mem_data_valid = 1'b1; bus_rr.mem_rd_data = 32'h0BAD;
      @(negedge clk);
      chk("fl_late_ack", bus_rr.rsp_valid, 4'b0000);
      chk("fl_rsp_data", bus_rr.rsp_data, 32'hDEAD_BEEF);
      bus_rr.mem_data_valid = 1'b0;
      issue(3, 32'h300, 1'b0, 32'h0);
      @(negedge clk);
      chk("fl_next_grant", bus_rr.grant, 4'b1000);
      bus_rr.req_valid = 4'h0;
      @(negedge clk);
      bus_rr.mem_data_valid = 1'b1; bus_rr.mem_rd_data = 32'hCAFE_0003;
      @(negedge clk);
      chk("fl_next_rsp", bus_rr.rsp_valid, 4'b1000);
      chk("fl_next_data", bus_rr.rsp_data, 32'hCAFE_0003);
      bus_rr.mem_data_valid = 1'b0;
      @(negedge clk);

      // Stall for three edges during REQ stretches grant/mem_req_valid to four cycles.
      issue(1, 32'h104, 1'b0, 32'h0);
      @(negedge clk);
      chk("st_grant_0", bus_rr.grant, 4'b0010);
      bus_rr.req_valid = 4'h0;
      bus_rr.system_stall = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("st_grant_held", bus_rr.grant, 4'b0010);
         chk("st_mreq_held", bus_rr.mem_req_valid, 1'b1);
      end
      bus_rr.system_stall = 1'b0;
      @(negedge clk);
      chk("st_grant_end", bus_rr.grant, 4'b0000);
      chk("st_wait_busy", bus_rr.busy, 1'b1);
      bus_rr.mem_data_valid = 1'b1; bus_rr.mem_rd_data = 32'h11;
      @(negedge clk);
      chk("st_rsp", bus_rr.rsp_valid, 4'b0010);
      bus_rr.mem_data_valid = 1'b0;
      @(negedge clk);

      // Asynchronous reset mid-WAIT clears outputs before the next clock edge.
      issue(2, 32'h208, 1'b1, 32'h77);
      @(negedge clk);
      bus_rr.req_valid = 4'h0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("ar_busy", bus_rr.busy, 1'b0);
      chk("ar_mem_addr", bus_rr.mem_addr, 32'h0);
      chk("ar_mem_we", bus_rr.mem_we, 1'b0);
      chk("ar_mem_wdata", bus_rr.mem_wdata, 32'h0);
      chk("ar_rsp_data", bus_rr.rsp_data, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

`ifdef ARB_TIMEOUT_EN
      // No ack: watchdog responds eight cycles after WAIT is entered.
      issue(3, 32'h30C, 1'b0, 32'h0);
      @(negedge clk);
      chk("to_grant", bus_rr.grant, 4'b1000);
      bus_rr.req_valid = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("to_not_yet", bus_rr.rsp_valid, 4'b0000);
      end
      @(negedge clk);
      chk("to_err", bus_rr.timeout_err, 1'b1);
      chk("to_rsp_valid", bus_rr.rsp_valid, 4'b1000);
      chk("to_rsp_data", bus_rr.rsp_data, 32'h0);
      @(negedge clk);
      chk("to_err_pulse", bus_rr.timeout_err, 1'b0);
`endif

      // Randomized traffic: requesters follow the hold-until-grant handshake.
      prev_g = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (bus_rr.req_valid[i] && e_grant[i] && !prev_g[i]) begin
               bus_rr.req_valid[i] = 1'b0;
            end else if (!bus_rr.req_valid[i] && ($urandom_range(0, 3) == 0)) begin
               bus_rr.req_addr[i*AW +: AW]  = $urandom;
               bus_rr.req_we[i]             = 1'($urandom_range(0, 1));
               bus_rr.req_wdata[i*DW +: DW] = $urandom;
               bus_rr.req_valid[i]          = 1'b1;
            end
         end
         prev_g = e_grant;
         bus_rr.mem_data_valid = ($urandom_range(0, 2) == 0);
         bus_rr.mem_rd_data    = $urandom;
         bus_rr.system_stall   = ($urandom_range(0, 9) == 0);
         bus_rr.system_flush   = ($urandom_range(0, 39) == 0);
      end
      bus_rr.system_stall = 1'b0; bus_rr.system_flush = 1'b0; bus_rr.req_valid = 4'h0;
      bus_rr.mem_data_valid = 1'b1;
      repeat (5) @(negedge clk);
      bus_rr.mem_data_valid = 1'b0;
      @(negedge clk);
      chk("end_idle", bus_rr.busy, 1'b0);
      chk("fp_grants_seen", 64'(fp_grants >= 5), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
